// File: rtl/code_cache_fill_pkg.sv
// Shared code-cache definitions: geometry, FSM encodings and the cData bus bit-field layout
// used by both the core-side cache and the code-cache peripheral.
package cc_pkg;

    localparam int unsigned CC_ADDR_W = 6;
    localparam int unsigned CC_DATA_W = 8;
    localparam int unsigned CC_DEPTH  = 1 << CC_ADDR_W;

    typedef logic [1:0] cc_state_t;
    localparam cc_state_t EMPTY  = 2'd0;
    localparam cc_state_t FILL   = 2'd1;
    localparam cc_state_t READY  = 2'd2;
    localparam cc_state_t HALTED = 2'd3;

    // cData[15:0] = {halt, fill, addr[5:0], data[7:0]}
    localparam int unsigned CD_DATA_LSB = 0;
    localparam int unsigned CD_DATA_MSB = 7;
    localparam int unsigned CD_ADDR_LSB = 8;
    localparam int unsigned CD_ADDR_MSB = 13;
    localparam int unsigned CD_FILL_BIT = 14;
    localparam int unsigned CD_HALT_BIT = 15;

endpackage

// File: rtl/code_cache_ram.sv
// Instruction store: one synchronous write port and one synchronous read port;
// a read of the address being written in the same cycle returns the new byte.
module code_cache_ram #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/code_cache_fill.sv
// Core-side code cache: captures streamed fill writes, tracks per-line valid bits,
// serves 1-cycle fetches and applies the peripheral's halt request to the core.
module code_cache_fill
    import cc_pkg::*;
#(
    parameter int unsigned ADDR_W = CC_ADDR_W,
    parameter int unsigned DATA_W = CC_DATA_W,
    parameter int unsigned DEPTH  = 1 << ADDR_W
) (
    input  logic              fastClk,
    input  logic              nRst,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              halt_req,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    output logic              fetch_stall,
    output logic              halted,
    output logic              fill_done,
    output logic [ADDR_W:0]   fill_count
);

    localparam logic [ADDR_W:0] COUNT_MAX = (ADDR_W+1)'(DEPTH);

    cc_state_t         state;
    logic              from_ready;
    logic [DEPTH-1:0]  valid;
    logic              hit;
    logic              fetch_ok;
    logic              entry;
    logic [DATA_W-1:0] rd_data;

    always_comb begin
        halted      = (state == EMPTY) || (state == HALTED) || ((state == FILL) && !from_ready);
        // A line being written this cycle counts as present (served by the RAM bypass).
        hit         = valid[fetch_addr] || (fill_en && (fill_addr == fetch_addr));
        fetch_ok    = fetch_req && !halted && hit;
        fetch_stall = fetch_req && !fetch_ok;
        entry       = fill_en && (state != FILL);
    end

    always_ff @(posedge fastClk or negedge nRst) begin
        if (!nRst) begin
            state      <= EMPTY;
            from_ready <= 1'b0;
            fill_done  <= 1'b0;
        end else begin
            fill_done <= 1'b0;
            case (state)
                EMPTY: begin
                    if (fill_en) begin
                        state      <= FILL;
                        from_ready <= 1'b0;
                    end
                end
                FILL: begin
                    if (!fill_en) begin
                        state     <= READY;
                        fill_done <= 1'b1;
                    end
                end
                READY: begin
                    if (fill_en) begin
                        state      <= FILL;
                        from_ready <= 1'b1;
                    end else if (halt_req) begin
                        state <= HALTED;
                    end
                end
                HALTED: begin
                    if (fill_en) begin
                        state      <= FILL;
                        from_ready <= 1'b0;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // The entry write lands after the bitmap clear, so the first word of a fill is kept.
    always_ff @(posedge fastClk or negedge nRst) begin
        if (!nRst) begin
            valid      <= '0;
            fill_count <= '0;
        end else if (entry) begin
            valid      <= DEPTH'(1) << fill_addr;
            fill_count <= (ADDR_W+1)'(1);
        end else if (fill_en) begin
            valid[fill_addr] <= 1'b1;
            if (!valid[fill_addr] && (fill_count != COUNT_MAX)) begin
                fill_count <= fill_count + 1'b1;
            end
        end
    end

    always_ff @(posedge fastClk or negedge nRst) begin
        if (!nRst) begin
            fetch_valid <= 1'b0;
        end else begin
            fetch_valid <= fetch_ok;
        end
    end

    assign fetch_data = fetch_valid ? rd_data : '0;

    code_cache_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk  (fastClk),
        .we   (fill_en),
        .waddr(fill_addr),
        .wdata(fill_data),
        .re   (fetch_ok),
        .raddr(fetch_addr),
        .rdata(rd_data)
    );

endmodule

// File: tb/tb_code_cache_fill.sv
// Scoreboard bench for code_cache_fill: directed scenarios plus randomized traffic,
// checked against a line-level behavioural model of the cache.
module tb_code_cache_fill;

    logic       fastClk = 1'b0;
    logic       nRst = 1'b0;
    logic       fill_en = 1'b0;
    logic [5:0] fill_addr = '0;
    logic [7:0] fill_data = '0;
    logic       halt_req = 1'b0;
    logic       fetch_req = 1'b0;
    logic [5:0] fetch_addr = '0;
    logic [7:0] fetch_data;
    logic       fetch_valid;
    logic       fetch_stall;
    logic       halted;
    logic       fill_done;
    logic [6:0] fill_count;

    always #5 fastClk = ~fastClk;

    code_cache_fill #(
        .ADDR_W(6),
        .DATA_W(8)
    ) dut (
        .fastClk    (fastClk),
        .nRst       (nRst),
        .fill_en    (fill_en),
        .fill_addr  (fill_addr),
        .fill_data  (fill_data),
        .halt_req   (halt_req),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .fetch_valid(fetch_valid),
        .fetch_stall(fetch_stall),
        .halted     (halted),
        .fill_done  (fill_done),
        .fill_count (fill_count)
    );

    typedef struct {
        bit       halted;
        bit       stall;
        bit       fv;
        bit [7:0] data;
        bit       done;
        int       count;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Behavioural model: what the core sees, in terms of loaded lines.
    typedef enum {M_EMPTY, M_FILL, M_READY, M_HALTED} phase_t;
    phase_t   phase = M_EMPTY;
    bit       fill_started_ready = 1'b0;
    bit [7:0] m_mem[64];
    bit       line_ok[64];
    bit       r_fv = 1'b0;
    bit [7:0] r_data = '0;
    bit       r_done = 1'b0;
    bit       last_stall = 1'b0;

    function automatic int lines_loaded();
        int n = 0;
        for (int i = 0; i < 64; i++) n += int'(line_ok[i]);
        return n;
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic drive(input bit rst, input bit fe, input bit [5:0] fa, input bit [7:0] fd,
                         input bit hr, input bit fr, input bit [5:0] ra);
        exp_t e;
        bit   core_halted, bypass, present;
        @(negedge fastClk);
        nRst       = !rst;
        fill_en    = fe;
        fill_addr  = fa;
        fill_data  = fd;
        halt_req   = hr;
        fetch_req  = fr;
        fetch_addr = ra;
        if (rst) begin
            phase  = M_EMPTY;
            r_fv   = 1'b0;
            r_data = '0;
            r_done = 1'b0;
            for (int i = 0; i < 64; i++) line_ok[i] = 1'b0;
        end
        core_halted = (phase == M_EMPTY) || (phase == M_HALTED) ||
                      ((phase == M_FILL) && !fill_started_ready);
        bypass  = fe && (fa == ra);
        present = line_ok[ra] || bypass;
        e.halted = core_halted;
        e.stall  = fr && (core_halted || !present);
        e.fv     = r_fv;
        e.data   = r_fv ? r_data : 8'h00;
        e.done   = r_done;
        e.count  = lines_loaded();
        sb.push_back(e);
        last_stall = e.stall;
        if (!rst) begin
            r_fv = fr && !core_halted && present;
            if (r_fv) r_data = bypass ? fd : m_mem[ra];
            r_done = (phase == M_FILL) && !fe;
            if (fe) begin
                if (phase != M_FILL) begin
                    for (int i = 0; i < 64; i++) line_ok[i] = 1'b0;
                    fill_started_ready = (phase == M_READY);
                    phase = M_FILL;
                end
                m_mem[fa]   = fd;
                line_ok[fa] = 1'b1;
            end else if (phase == M_FILL) begin
                phase = M_READY;
            end else if (phase == M_READY && hr) begin
                phase = M_HALTED;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: pops one expectation per cycle and compares what the DUT presents.
    initial begin
        exp_t e;
        forever begin
            @(negedge fastClk);
            #4;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("halted",      32'(halted),      32'(e.halted));
                chk("fetch_stall", 32'(fetch_stall), 32'(e.stall));
                chk("fetch_valid", 32'(fetch_valid), 32'(e.fv));
                chk("fetch_data",  32'(fetch_data),  32'(e.data));
                chk("fill_done",   32'(fill_done),   32'(e.done));
                chk("fill_count",  32'(fill_count),  32'(e.count));
            end
        end
    end

    initial begin
        bit       fe_on;
        bit       fr, rst;
        bit [5:0] ra, fa;

        // 1: full fill, close, fetch line 17
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 64; i++) drive(0, 1, 6'(i), 8'(i) ^ 8'hA5, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 17);
        idle(2);

        // 2: repeated writes to one line count once
        for (int i = 0; i < 4; i++) drive(0, 1, 5, 8'h3C, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 5);
        idle(1);

        // 3a: fill from READY, fetch an already-loaded line mid-fill
        for (int i = 0; i < 10; i++) drive(0, 1, 6'(i), 8'(i) ^ 8'h5A, 0, (i == 6), 3);
        drive(0, 0, 0, 0, 0, 0, 0);
        // 3b: fetch line 9 from cycle 2, stalls until written (bypass hit)
        for (int i = 0; i < 10; i++) drive(0, 1, 6'(i), 8'(i) + 8'h70, 0, (i >= 2), 9);
        drive(0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // 4: halt, stalled fetch held across a fill from HALTED
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 6'(i), 8'hC0 + 8'(i), 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        idle(1);

        // 5: reset mid-fill, partial re-fill, fetch of unloaded line stalls
        for (int i = 0; i < 30; i++) drive(0, 1, 6'(i), 8'(i) * 8'd3, 0, 0, 0);
        drive(1, 0, 30, 8'h99, 0, 0, 0);
        idle(1);
        for (int i = 0; i < 6; i++) drive(0, 1, 6'(i), 8'h20 + 8'(i), 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 0, 1, 10);
        idle(1);

        // 6: full fill then short fill; upper lines invalid
        for (int i = 0; i < 64; i++) drive(0, 1, 6'(i), 8'($urandom), 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) drive(0, 1, 6'(i), 8'($urandom), 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 1, 40);
        drive(0, 0, 0, 0, 0, 1, 9);
        idle(1);

        // Randomized traffic; the core holds a stalled request stable.
        fe_on = 1'b0;
        ra = '0;
        fa = '0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 11) == 0) fe_on = !fe_on;
            fa = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fa + 6'(($urandom_range(0, 3) != 0));
            if (!last_stall) begin
                fr = ($urandom_range(0, 1) == 1);
                ra = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 12)) : 6'($urandom);
            end else begin
                fr = 1'b1;
            end
            if (rst) drive(1, 0, fa, 8'($urandom), 0, 0, ra);
            else     drive(0, fe_on, fa, 8'($urandom), ($urandom_range(0, 15) == 0), fr, ra);
        end
        idle(3);

        #5;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
